// File: rtl/des_wb_sequencer.sv
// Wishbone pipelined master that runs one DES block operation on the DES register
// block: load input/key/ctrl, poll status, read the result, then clear ctrl.
module des_wb_sequencer #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          ACK_TIMEOUT  = 16,
    parameter int          POLL_LIMIT   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_encrypt,
    input  logic [63:0] i_key,
    input  logic [63:0] i_block,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [63:0] o_result,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);

    // state  | meaning
    // IDLE   | waiting for i_start
    // REQ    | strobe asserted for the current step
    // WAIT   | request accepted, waiting for ack
    // FINISH | one-cycle o_done, back to IDLE
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FINISH} state_t;

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int PW = $clog2(POLL_LIMIT + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(ACK_TIMEOUT - 1);
    localparam logic [PW-1:0] POLL_LOAD  = PW'(POLL_LIMIT - 1);

    state_t        state, next_state;
    logic [3:0]    step;
    logic [63:0]   key_q;
    logic [63:0]   block_q;
    logic          enc_q;
    logic [TW-1:0] timer;
    logic [PW-1:0] poll_cnt;
    logic          err_q;
    logic [63:0]   res_buf;
    logic          ack_ok;
    logic          timed_out;

    assign ack_ok    = (state == WAIT) && i_wb_ack;
    assign timed_out = (state == REQ || state == WAIT) && (timer == '0) && !ack_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_start) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (timed_out) begin
                    next_state = FINISH;
                end else if (!i_wb_stall) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (ack_ok) begin
                    next_state = (step == 4'd8) ? FINISH : REQ;
                end else if (timed_out) begin
                    next_state = FINISH;
                end
            end
            FINISH: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_wb_cyc  = 1'b0;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = '0;
        o_wb_data = '0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        o_error   = 1'b0;
        case (state)
            REQ: begin
                o_wb_cyc = 1'b1;
                o_wb_stb = 1'b1;
                o_busy   = 1'b1;
                o_wb_we  = 1'b1;
                case (step)
                    4'd0: begin
                        o_wb_addr = BASE_ADDRESS + 32'h00;
                        o_wb_data = block_q[31:0];
                    end
                    4'd1: begin
                        o_wb_addr = BASE_ADDRESS + 32'h04;
                        o_wb_data = block_q[63:32];
                    end
                    4'd2: begin
                        o_wb_addr = BASE_ADDRESS + 32'h10;
                        o_wb_data = key_q[31:0];
                    end
                    4'd3: begin
                        o_wb_addr = BASE_ADDRESS + 32'h14;
                        o_wb_data = key_q[63:32];
                    end
                    4'd4: begin
                        o_wb_addr = BASE_ADDRESS + 32'h18;
                        o_wb_data = {30'b0, enc_q, 1'b1};
                    end
                    4'd5: begin
                        o_wb_addr = BASE_ADDRESS + 32'h1C;
                        o_wb_we   = 1'b0;
                    end
                    4'd6: begin
                        o_wb_addr = BASE_ADDRESS + 32'h08;
                        o_wb_we   = 1'b0;
                    end
                    4'd7: begin
                        o_wb_addr = BASE_ADDRESS + 32'h0C;
                        o_wb_we   = 1'b0;
                    end
                    default: begin
                        o_wb_addr = BASE_ADDRESS + 32'h18;
                    end
                endcase
            end
            WAIT: begin
                o_wb_cyc = 1'b1;
                o_busy   = 1'b1;
            end
            FINISH: begin
                o_done  = 1'b1;
                o_error = err_q;
            end
            default: ;
        endcase
    end

    // Timer is a per-transaction down-counter reloaded on every entry to REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            step     <= '0;
            key_q    <= '0;
            block_q  <= '0;
            enc_q    <= 1'b0;
            timer    <= '0;
            poll_cnt <= '0;
            err_q    <= 1'b0;
            res_buf  <= '0;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        key_q    <= i_key;
                        block_q  <= i_block;
                        enc_q    <= i_encrypt;
                        step     <= '0;
                        timer    <= TIMER_LOAD;
                        poll_cnt <= POLL_LOAD;
                        err_q    <= 1'b0;
                    end
                end
                REQ, WAIT: begin
                    timer <= timer - TW'(1);
                    if (timed_out) begin
                        err_q <= 1'b1;
                    end
                    if (ack_ok) begin
                        timer <= TIMER_LOAD;
                        case (step)
                            4'd5: begin
                                if (i_wb_data[0]) begin
                                    step <= 4'd6;
                                end else if (poll_cnt == '0) begin
                                    // Poll gave up: skip the output reads, still clear CTRL.
                                    step  <= 4'd8;
                                    err_q <= 1'b1;
                                end else begin
                                    poll_cnt <= poll_cnt - PW'(1);
                                end
                            end
                            4'd6: begin
                                res_buf[31:0] <= i_wb_data;
                                step          <= 4'd7;
                            end
                            4'd7: begin
                                res_buf[63:32] <= i_wb_data;
                                step           <= 4'd8;
                            end
                            4'd8: begin
                                if (!err_q) begin
                                    o_result <= res_buf;
                                end
                            end
                            default: step <= step + 4'd1;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_des_wb_sequencer.sv
// Bench for des_wb_sequencer: a DES register-block responder plus a step-list model
// of the expected bus traffic, result, error and latency.
module tb_des_wb_sequencer;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [63:0] KAT_K  = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] KAT_PT = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] KAT_CT = 64'h85E8_1354_0F0A_B405;
    localparam int          DES_LAT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_encrypt = 1'b0;
    logic [63:0] i_key = '0;
    logic [63:0] i_block = '0;
    logic        o_busy, o_done, o_error;
    logic [63:0] o_result;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_wb_addr, o_wb_data;
    logic        i_wb_ack = 1'b0;
    logic        i_wb_stall = 1'b0;
    logic [31:0] i_wb_data = '0;

    des_wb_sequencer #(.BASE_ADDRESS(BASE), .ACK_TIMEOUT(16), .POLL_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_encrypt(i_encrypt),
        .i_key(i_key), .i_block(i_block), .o_busy(o_busy), .o_done(o_done),
        .o_error(o_error), .o_result(o_result), .o_wb_cyc(o_wb_cyc),
        .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
        .i_wb_data(i_wb_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stand-in for the DES core: exact for the known-answer pair, deterministic otherwise.
    function automatic logic [63:0] engine(input logic [63:0] k, input logic [63:0] b, input logic e);
        if (k == KAT_K && b == KAT_PT && e) return KAT_CT;
        if (k == KAT_K && b == KAT_CT && !e) return KAT_PT;
        return e ? ((b ^ k) + 64'h0123_0000_0000_4567) : ((b ^ ~k) - 64'h89);
    endfunction

    // Model state for the operation in flight
    bit          m_active = 0;
    logic [63:0] m_key, m_block;
    logic        m_enc;
    int          m_step, m_zero, m_tx;
    bit          m_poll_err;
    logic [63:0] exp_result = '0;

    function automatic void exp_tx(input int s, output logic [31:0] a, output logic w,
                                   output logic [31:0] d);
        w = 1'b1;
        d = '0;
        case (s)
            0: begin a = BASE + 32'h00; d = m_block[31:0];  end
            1: begin a = BASE + 32'h04; d = m_block[63:32]; end
            2: begin a = BASE + 32'h10; d = m_key[31:0];    end
            3: begin a = BASE + 32'h14; d = m_key[63:32];   end
            4: begin a = BASE + 32'h18; d = {30'b0, m_enc, 1'b1}; end
            5: begin a = BASE + 32'h1C; w = 1'b0; end
            6: begin a = BASE + 32'h08; w = 1'b0; end
            7: begin a = BASE + 32'h0C; w = 1'b0; end
            8: begin a = BASE + 32'h18; end
            default: begin a = 32'hFFFF_FFFF; w = 1'bx; end
        endcase
    endfunction

    // Responder configuration and peripheral register state
    int          cfg_stall = 0;
    bit          cfg_noack = 0;
    bit          cfg_poll_never = 0;
    logic [31:0] r_in [2];
    logic [31:0] r_kreg [2];
    logic [31:0] r_ctrl = '0;
    logic [63:0] r_out = '0;
    bit          r_sts = 0;
    int          r_timer = 0;
    bit          pend_ack = 0;
    logic [31:0] pend_data = '0;
    bit          req_seen = 0;
    int          stall_left = 0;
    logic [31:0] held_addr, held_data;
    logic        held_we;

    // Responder plus the per-cycle compare against the model
    always @(negedge clk) begin
        logic [31:0] ea, ed, off;
        logic        ew;
        if (!reset) begin
            if (o_wb_stb) check("stb_without_cyc", o_wb_cyc, 1'b1);
            if (o_error) check("error_without_done", o_done, 1'b1);
            if (o_wb_stb && !o_wb_we) check("read_data_zero", o_wb_data, 32'h0);
        end
        i_wb_ack  = pend_ack;
        i_wb_data = pend_ack ? pend_data : 32'hDEAD_BEEF;
        if (pend_ack && m_active) begin
            if (m_step == 5) begin
                if (pend_data[0]) m_step = 6;
                else begin
                    m_zero++;
                    if (m_zero == 8) begin
                        m_step = 8;
                        m_poll_err = 1;
                    end
                end
            end else begin
                m_step++;
            end
        end
        pend_ack = 0;
        if (r_timer > 0) begin
            r_timer--;
            if (r_timer == 0) begin
                r_sts = 1;
                r_out = engine({r_kreg[1], r_kreg[0]}, {r_in[1], r_in[0]}, r_ctrl[1]);
            end
        end
        if (o_wb_cyc && o_wb_stb && !reset) begin
            if (!req_seen) begin
                req_seen   = 1;
                stall_left = cfg_stall;
                held_addr  = o_wb_addr;
                held_we    = o_wb_we;
                held_data  = o_wb_data;
            end else begin
                check("stall_addr", o_wb_addr, held_addr);
                check("stall_we", o_wb_we, held_we);
                check("stall_data", o_wb_data, held_data);
            end
            if (stall_left > 0) begin
                i_wb_stall = 1'b1;
                stall_left--;
            end else begin
                i_wb_stall = 1'b0;
                req_seen   = 0;
                m_tx++;
                if (m_active) begin
                    exp_tx(m_step, ea, ew, ed);
                    check("tx_addr", o_wb_addr, ea);
                    check("tx_we", o_wb_we, ew);
                    check("tx_data", o_wb_data, ed);
                end
                off = o_wb_addr - BASE;
                if (o_wb_we) begin
                    case (off)
                        32'h00: r_in[0] = o_wb_data;
                        32'h04: r_in[1] = o_wb_data;
                        32'h10: r_kreg[0] = o_wb_data;
                        32'h14: r_kreg[1] = o_wb_data;
                        32'h18: begin
                            r_ctrl  = o_wb_data;
                            r_sts   = 0;
                            r_timer = o_wb_data[0] ? DES_LAT : 0;
                        end
                        default: ;
                    endcase
                    pend_data = '0;
                end else begin
                    case (off)
                        32'h08: pend_data = r_out[31:0];
                        32'h0C: pend_data = r_out[63:32];
                        32'h1C: pend_data = {31'b0, r_sts && !cfg_poll_never};
                        default: pend_data = '0;
                    endcase
                end
                pend_ack = !(cfg_noack && off == 32'h14);
            end
        end else begin
            i_wb_stall = 1'b0;
            req_seen   = 0;
        end
    end

    // mode: 0 normal, 1 KEY_HI never acked, 2 STS never sets
    task automatic run_op(input logic [63:0] key, input logic [63:0] blk, input logic enc,
                          input int stall, input int mode, input int reset_at,
                          input bit busy_poke, input bit start_in_done, input int exp_lat);
        int  k;
        bit  done;
        bit  exp_err;
        int  lat;
        @(negedge clk);
        cfg_stall      = stall;
        cfg_noack      = (mode == 1);
        cfg_poll_never = (mode == 2);
        m_key = key; m_block = blk; m_enc = enc;
        m_step = 0; m_zero = 0; m_tx = 0; m_poll_err = 0; m_active = 1;
        i_start = 1'b1; i_key = key; i_block = blk; i_encrypt = enc;
        @(posedge clk);
        k = 0;
        done = 0;
        while (k < 600 && !done) begin
            @(negedge clk);
            k++;
            i_start = (busy_poke && k == 6);
            if (busy_poke && k == 6) begin
                i_key = ~key; i_block = ~blk; i_encrypt = ~enc;
            end
            if (k == reset_at) begin
                reset = 1'b1;
                m_active = 0;
                @(negedge clk);
                check("rst_cyc", o_wb_cyc, 1'b0);
                check("rst_stb", o_wb_stb, 1'b0);
                check("rst_done", o_done, 1'b0);
                check("rst_busy", o_busy, 1'b0);
                check("rst_result", o_result, 64'h0);
                reset = 1'b0;
                exp_result = '0;
                repeat (40) begin
                    @(negedge clk);
                    if (o_done || o_wb_cyc) check("rst_quiet", {o_done, o_wb_cyc}, 2'b00);
                end
                return;
            end
            if (o_done) done = 1;
        end
        check("done_seen", done, 1'b1);
        exp_err = (mode != 0);
        if (!exp_err) exp_result = engine(key, blk, enc);
        check("error", o_error, exp_err);
        check("result", o_result, exp_result);
        check("busy_in_done", o_busy, 1'b0);
        check("cyc_in_done", o_wb_cyc, 1'b0);
        lat = (mode == 1) ? (2 + stall) * 3 + 16 + 1 : (2 + stall) * m_tx + 1;
        check("latency", k, lat);
        if (exp_lat >= 0) check("latency_pinned", k, exp_lat);
        if (mode == 0) check("model_finished", m_step, 9);
        if (mode == 2) check("poll_tx_count", m_tx, 14);
        if (mode == 2) check("poll_err_model", m_poll_err, 1'b1);
        m_active = 0;
        if (start_in_done) begin
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
            check("start_in_done_ignored", {o_busy, o_wb_cyc}, 2'b00);
            @(negedge clk);
            check("still_idle", {o_busy, o_wb_cyc}, 2'b00);
        end else begin
            i_start = 1'b0;
            @(negedge clk);
            check("done_one_cycle", o_done, 1'b0);
        end
    endtask

    initial begin
        r_in[0] = '0; r_in[1] = '0; r_kreg[0] = '0; r_kreg[1] = '0;
        repeat (3) @(negedge clk);
        check("reset_cyc_stb_we", {o_wb_cyc, o_wb_stb, o_wb_we}, 3'b000);
        check("reset_addr", o_wb_addr, 32'h0);
        check("reset_data", o_wb_data, 32'h0);
        check("reset_status", {o_busy, o_done, o_error}, 3'b000);
        check("reset_result", o_result, 64'h0);
        reset = 1'b0;

        // Known-answer encrypt, zero-wait: 8 STS reads -> 2*(8+8)+1
        run_op(KAT_K, KAT_PT, 1'b1, 0, 0, -1, 0, 0, 33);
        check("kat_encrypt", o_result, 64'h85E8_1354_0F0A_B405);
        run_op(KAT_K, KAT_CT, 1'b0, 0, 0, -1, 0, 0, -1);
        check("kat_decrypt", o_result, 64'h0123_4567_89AB_CDEF);
        run_op(KAT_K, KAT_PT, 1'b1, 3, 0, -1, 0, 0, -1);
        check("kat_stalled", o_result, 64'h85E8_1354_0F0A_B405);
        // KEY_HI never acked: accepted 7 cycles in, 16-cycle budget
        run_op(64'h0F1E_2D3C_4B5A_6978, 64'h1111_2222_3333_4444, 1'b1, 0, 1, -1, 0, 0, 23);
        check("noack_keeps_result", o_result, 64'h85E8_1354_0F0A_B405);
        // STS never sets: 5 writes + 8 reads + CTRL clear -> 2*14+1
        run_op(64'h0F1E_2D3C_4B5A_6978, 64'h1111_2222_3333_4444, 1'b0, 0, 2, -1, 0, 0, 29);
        check("poll_keeps_result", o_result, 64'h85E8_1354_0F0A_B405);
        run_op(KAT_K, KAT_PT, 1'b1, 0, 0, 20, 0, 0, -1);
        run_op(KAT_K, KAT_CT, 1'b0, 1, 0, -1, 1, 1, -1);
        check("after_reset_decrypt", o_result, 64'h0123_4567_89AB_CDEF);
        for (int i = 0; i < 12; i++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 0, -1, 0, 0, -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
